// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Encoding is {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Occupancy needs one more bit than the pointers so that DEPTH itself fits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, synchronous enabled read, no reset.
module fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-write contents, so a full FIFO reading and writing the same slot returns the old entry.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointers, occupancy and status flags around a fifo_mem instance.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_en,
  input  logic                        r_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        clr_err,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  udf_set;
  logic                  rd_seen;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_op_e              op;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A read frees a slot in the same edge, so a full FIFO may still take a write alongside it.
  assign rd_acc  = r_en && !empty;
  assign wr_acc  = w_en && (!full || rd_acc);
  assign ovf_set = w_en && full && !r_en;
  assign udf_set = r_en && empty;
  assign op      = fifo_op_e'({wr_acc, rd_acc});

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case (op)
        OP_WRITE: count <= count + CW'(1);
        OP_READ:  count <= count - CW'(1);
        default:  count <= count;
      endcase
    end
  end

  // Storage has no reset, so data_out reads as zero until the first read after reset loads it.
  always_ff @(posedge clk) begin
    if (rst)         rd_seen <= 1'b0;
    else if (rd_acc) rd_seen <= 1'b1;
  end

  assign data_out = rd_seen ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc && !rst),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: queue-based reference model checked every cycle, plus literal spot checks.
module tb_param_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_in;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  param_sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .r_en         (r_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int            check_count = 0;
  int            pass_count  = 0;
  bit            checking    = 1'b0;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_count++;
  endtask

  task automatic checkOutput();
    checkValue("count",        32'(count),        32'(m_q.size()));
    checkValue("full",         32'(full),         32'(m_q.size() == DEPTH));
    checkValue("empty",        32'(empty),        32'(m_q.size() == 0));
    checkValue("almost_full",  32'(almost_full),  32'(m_q.size() >= AF));
    checkValue("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE));
    checkValue("data_out",     32'(data_out),     32'(m_dout));
    checkValue("overflow",     32'(overflow),     32'(m_ovf));
    checkValue("underflow",    32'(underflow),    32'(m_udf));
  endtask

  // Compare process: DUT against model on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (checking) checkOutput();
  end

  // Drive one cycle of inputs, let the edge happen, then advance the model by the FIFO's rules.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d,
                               input logic clr, input logic rs);
    bit was_full;
    bit was_empty;
    bit rd;
    bit wr;
    w_en = w; r_en = r; data_in = d; clr_err = clr; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      checking = 1'b1;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      rd = r && !was_empty;
      wr = w && (!was_full || rd);
      if (rd) m_dout = m_q.pop_front();
      if (wr) m_q.push_back(d);
      if (w && !wr)         m_ovf = 1'b1;
      else if (clr)         m_ovf = 1'b0;
      if (r && was_empty)   m_udf = 1'b1;
      else if (clr)         m_udf = 1'b0;
    end
    #2;
  endtask

  task automatic doWrite(input logic [DW-1:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic doRead();
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0; clr_err = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    checkValue("reset_count", 32'(count), 32'd0);
    checkValue("reset_empty", 32'(empty), 32'd1);
    checkValue("reset_ae",    32'(almost_empty), 32'd1);
    checkValue("reset_dout",  32'(data_out), 32'd0);

    // Fill in order, then drain in order with one-cycle read latency.
    for (int k = 1; k <= 8; k++) begin
      doWrite(DW'(k));
      if (k == 5) checkValue("fill_af_at5", 32'(almost_full), 32'd0);
      if (k == 6) checkValue("fill_af_at6", 32'(almost_full), 32'd1);
    end
    checkValue("fill_full", 32'(full), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      doRead();
      checkValue("drain_data", 32'(data_out), 32'(k));
    end
    checkValue("drain_empty", 32'(empty), 32'd1);

    // Overflow on a full FIFO leaves contents intact.
    for (int k = 1; k <= 8; k++) doWrite(DW'(k));
    doWrite(8'hFF);
    checkValue("ovf_flag",  32'(overflow), 32'd1);
    checkValue("ovf_count", 32'(count), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      doRead();
      checkValue("ovf_drain", 32'(data_out), 32'(k));
    end
    checkValue("ovf_sticky", 32'(overflow), 32'd1);
    doClear();
    checkValue("ovf_clear", 32'(overflow), 32'd0);

    // Underflow on empty; a set in the same cycle as clr_err wins.
    doRead();
    checkValue("udf_flag", 32'(underflow), 32'd1);
    checkValue("udf_dout", 32'(data_out), 32'h08);
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b0);
    checkValue("udf_set_wins", 32'(underflow), 32'd1);
    doClear();
    checkValue("udf_clear", 32'(underflow), 32'd0);

    // Simultaneous read and write while full.
    for (int k = 1; k <= 8; k++) doWrite(DW'(k));
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    checkValue("both_full_count", 32'(count), 32'd8);
    checkValue("both_full_ovf",   32'(overflow), 32'd0);
    checkValue("both_full_dout",  32'(data_out), 32'h01);
    for (int k = 2; k <= 8; k++) begin
      doRead();
      checkValue("both_full_drain", 32'(data_out), 32'(k));
    end
    doRead();
    checkValue("both_full_last", 32'(data_out), 32'hAA);

    // Simultaneous read and write while empty: only the write lands.
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    checkValue("both_empty_count", 32'(count), 32'd1);
    checkValue("both_empty_udf",   32'(underflow), 32'd1);
    checkValue("both_empty_dout",  32'(data_out), 32'hAA);
    doRead();
    checkValue("both_empty_read", 32'(data_out), 32'h55);
    doClear();

    // Interleaved traffic wrapping both pointers more than twice.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, (i % 3) != 0, DW'(8'h30 + i), 1'b0, 1'b0);
    checkValue("wrap_count", 32'(count), 32'd7);
    checkValue("wrap_dout",  32'(data_out), 32'h3C);
    for (int i = 0; i < 7; i++) doRead();
    checkValue("wrap_last",  32'(data_out), 32'h43);
    checkValue("wrap_empty", 32'(empty), 32'd1);

    // Reset in mid-operation discards entries and flags.
    doRead();
    for (int k = 0; k < 5; k++) doWrite(DW'(8'h61 + k));
    checkValue("pre_rst_count", 32'(count), 32'd5);
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    checkValue("rst_count", 32'(count), 32'd0);
    checkValue("rst_empty", 32'(empty), 32'd1);
    checkValue("rst_dout",  32'(data_out), 32'd0);
    checkValue("rst_udf",   32'(underflow), 32'd0);
    checkValue("rst_ovf",   32'(overflow), 32'd0);
    doWrite(8'h77);
    checkValue("post_rst_hold", 32'(data_out), 32'd0);
    doRead();
    checkValue("post_rst_read", 32'(data_out), 32'h77);

    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold; 1 <= AF_LEVEL <= DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold; 0 <= AE_LEVEL < AF_LEVEL.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- w_en  in  1  write request.
- r_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- clr_err  in  1  clears sticky error flags.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a write was dropped.
- underflow  out  1  sticky; a read was dropped.

Function
REQ-006 SHALL accept a write when w_en=1 and (full=0 or an accepted read occurs in the same cycle); mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-007 SHALL accept a read when r_en=1 and empty=0; data_out <= mem[rd_ptr] at that edge (1-cycle latency), rd_ptr increments.
REQ-008 SHALL hold data_out unchanged in every cycle without an accepted read.
REQ-009 SHALL wrap rd_ptr/wr_ptr ($clog2(DEPTH) bits) from DEPTH-1 to 0 with no gap.
REQ-010 SHALL update count per edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-011 SHALL, when full and w_en=r_en=1, accept both; count stays DEPTH; written entry is the slot just vacated.
REQ-012 SHALL, when empty and w_en=r_en=1, accept only the write; count becomes 1; underflow sets; data_out holds.
REQ-013 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count only (no input-to-output path).
REQ-014 SHALL set overflow on any cycle with w_en=1, full=1, r_en=0; the write is discarded and memory/pointers are untouched.
REQ-015 SHALL set underflow on any cycle with r_en=1, empty=1.
REQ-016 SHALL clear overflow/underflow on clr_err=1; a set condition in the same cycle wins over clr_err.
REQ-017 SHALL give read-after-write ordering: a value written at edge N is readable from edge N+1 (no same-cycle bypass when empty).

Reset
REQ-018 SHALL, on rst=1 at a rising edge: rd_ptr=0, wr_ptr=0, count=0, data_out=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-019 SHALL give rst priority over w_en, r_en and clr_err in the same cycle; memory contents are not reset.
REQ-020 SHALL, on reset mid-operation, discard all stored entries; the first read after reset returns the first post-reset write.

Structure
REQ-021 SHALL take default DEPTH/DATA_WIDTH and a count-width helper function from shared package fifo_pkg.
REQ-022 SHALL place storage in sub-module fifo_mem (simple dual-port, synchronous write, synchronous read, no reset); pointers, count and flags stay in param_sync_fifo.

Verification
REQ-023 Reset, then 8 writes 0x01..0x08 -> full=1 after the 8th, almost_full=1 from count 6; 8 reads -> data_out 0x01..0x08 in order, each one cycle after r_en; empty=1 at end.
REQ-024 Full FIFO, one write 0xFF with r_en=0 -> overflow=1, count stays 8, subsequent 8 reads return the original data, no 0xFF.
REQ-025 Empty FIFO, r_en=1 -> underflow=1, data_out unchanged; clr_err=1 next cycle -> underflow=0.
REQ-026 Full FIFO, w_en=r_en=1 with 0xAA for 1 cycle -> count stays 8, overflow=0; draining returns 0x02..0x08 then 0xAA.
REQ-027 20 writes/reads interleaved to wrap pointers twice -> in-order data, count never exceeds 8; almost_empty high exactly when count <= 2.
REQ-028 rst=1 asserted with count=5 and w_en=1 -> next cycle count=0, empty=1, data_out=0, flags 0.
